// File: rtl/freq_div_ratio_ctrl.sv
// Ratio update controller for the programmable divider: range-checked config port,
// one-deep pending slot, and a 4-phase req/ack handshake with per-phase timeouts.
module freq_div_ratio_ctrl #(
    parameter int MIN_RATIO   = 2,
    parameter int RESET_RATIO = 10,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic [9:0] cfg_ratio,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_clr_err,
    output logic [9:0] ratio,
    output logic       ratio_upd_req,
    input  logic       ratio_upd_ack,
    output logic [9:0] active_ratio,
    output logic       busy,
    output logic       err_range,
    output logic       err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] TMR_MAX   = {TW{1'b1}};
    localparam logic [TW-1:0] TMR_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [9:0]    MIN_R     = 10'(MIN_RATIO);
    localparam logic [9:0]    RESET_R   = 10'(RESET_RATIO);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt;
    logic [TW-1:0]          timer_r;
    logic [TW-1:0]          timer_nxt;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [9:0]             pend_r;
    logic                   pend_vld_r;
    logic                   ack_s;
    logic                   accept_s;
    logic                   in_range_s;
    logic                   load_s;
    logic                   req_nxt;
    logic                   act_upd_s;
    logic                   tmo_s;

    assign ack_s      = sync_r[SYNC_STAGES-1];
    assign cfg_ready  = ~pend_vld_r;
    assign accept_s   = cfg_valid & ~pend_vld_r;
    assign in_range_s = (cfg_ratio >= MIN_R);
    assign busy       = (state_r != ST_IDLE) | pend_vld_r;

    // Acknowledge synchroniser; the only consumer of the raw ack input.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], ratio_upd_ack};
        end
    end

    // Handshake next-state, request level and phase timer.
    always_comb begin
        state_nxt = state_r;
        req_nxt   = ratio_upd_req;
        load_s    = 1'b0;
        act_upd_s = 1'b0;
        tmo_s     = 1'b0;
        timer_nxt = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (pend_vld_r) begin
                    load_s    = 1'b1;
                    req_nxt   = 1'b1;
                    state_nxt = ST_REQ;
                end else begin
                    req_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (timer_r == TMO_LAST) begin
                    req_nxt   = 1'b0;
                    tmo_s     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    req_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (timer_r == HOLD_LAST) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_REL;
                end else begin
                    req_nxt = 1'b1;
                end
            end
            ST_REL: begin
                req_nxt = 1'b0;
                if (!ack_s) begin
                    act_upd_s = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timer_r == TMO_LAST) begin
                    tmo_s     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_REL;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
        // Timer restarts on every state entry and saturates instead of wrapping.
        if (state_nxt != state_r) begin
            timer_nxt = TMR_ZERO;
        end else if (timer_r != TMR_MAX) begin
            timer_nxt = timer_r + TMR_ONE;
        end else begin
            timer_nxt = timer_r;
        end
    end

    // FSM state, timer and divider-facing registers.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            timer_r       <= TMR_ZERO;
            ratio_upd_req <= 1'b0;
            ratio         <= RESET_R;
            active_ratio  <= RESET_R;
        end else begin
            state_r       <= state_nxt;
            timer_r       <= timer_nxt;
            ratio_upd_req <= req_nxt;
            if (load_s) begin
                ratio <= pend_r;
            end
            if (act_upd_s) begin
                active_ratio <= ratio;
            end
        end
    end

    // Pending slot: filled by an in-range accept, emptied by the IDLE load.
    always_ff @(posedge clkin) begin
        if (rst) begin
            pend_r     <= RESET_R;
            pend_vld_r <= 1'b0;
        end else if (accept_s && in_range_s) begin
            pend_r     <= cfg_ratio;
            pend_vld_r <= 1'b1;
        end else if (load_s) begin
            pend_vld_r <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the clear cycle takes priority.
    always_ff @(posedge clkin) begin
        if (rst) begin
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (accept_s && !in_range_s) begin
                err_range <= 1'b1;
            end else if (cfg_clr_err) begin
                err_range <= 1'b0;
            end
            if (tmo_s) begin
                err_timeout <= 1'b1;
            end else if (cfg_clr_err) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_div_ratio_ctrl.sv
// Self-checking bench for freq_div_ratio_ctrl: directed handshake sequences, a vector
// table of single writes, and randomized writes checked against a transaction-level model.
module tb_freq_div_ratio_ctrl;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] cfg_ratio = 10'd0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_clr_err = 1'b0;
    logic [9:0] ratio;
    logic       ratio_upd_req;
    logic       dut_ack;
    logic [9:0] active_ratio;
    logic       busy;
    logic       err_range;
    logic       err_timeout;

    // Bench divider model: manual ack level or an auto-responder with programmable delays
    logic man_ack = 1'b0;
    logic auto_ack = 1'b0;
    bit   ack_auto = 1'b0;
    int   ack_dly = 3;
    int   rel_dly = 2;
    int   ack_cnt = 0;

    int   errors = 0;
    int   checks = 0;
    int   req_pulses = 0;
    logic req_prev = 1'b0;

    // Transaction model: in-range accepted ratios must be issued to the divider in order
    bit         mdl_en = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] last_exp;
    bit         err_exp;

    assign dut_ack = ack_auto ? auto_ack : man_ack;

    freq_div_ratio_ctrl dut (
        .clkin        (clkin),
        .rst          (rst),
        .cfg_ratio    (cfg_ratio),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_clr_err  (cfg_clr_err),
        .ratio        (ratio),
        .ratio_upd_req(ratio_upd_req),
        .ratio_upd_ack(dut_ack),
        .active_ratio (active_ratio),
        .busy         (busy),
        .err_range    (err_range),
        .err_timeout  (err_timeout)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clkin) begin
        #1;
        if (ratio_upd_req && !auto_ack) begin
            if (ack_cnt >= ack_dly) begin
                auto_ack = 1'b1;
                ack_cnt  = 0;
            end else begin
                ack_cnt++;
            end
        end else if (!ratio_upd_req && auto_ack) begin
            if (ack_cnt >= rel_dly) begin
                auto_ack = 1'b0;
                ack_cnt  = 0;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    always @(posedge clkin) begin
        #1;
        if (ratio_upd_req && !req_prev) begin
            req_pulses++;
            if (mdl_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req_ratio", {22'd0, ratio}, 32'hFFFF_FFFF);
                end else begin
                    check("issue_order", {22'd0, ratio}, {22'd0, exp_q.pop_front()});
                end
            end
        end
        req_prev = ratio_upd_req;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic write_cfg(input logic [9:0] v, output bit ok);
        logic rdy;
        ok = 1'b0;
        cfg_ratio = v;
        cfg_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rdy = cfg_ready;
            tick(1);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cfg_accept_timeout: write of %0d never accepted", v);
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_req(input string name, input int max);
        int n = 0;
        while (!ratio_upd_req && n < max) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, ratio_upd_req}, 32'd1);
    endtask

    task automatic clear_errors();
        cfg_clr_err = 1'b1;
        tick(1);
        cfg_clr_err = 1'b0;
    endtask

    typedef struct {
        logic [9:0] wr;
        logic       exp_err;
        logic [9:0] exp_active;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[6];
    bit   ok;
    int   n;
    int   p0;

    initial begin
        vecs[0] = '{wr: 10'd7,    exp_err: 1'b0, exp_active: 10'd7,    exp_pulses: 1};
        vecs[1] = '{wr: 10'd1,    exp_err: 1'b1, exp_active: 10'd7,    exp_pulses: 0};
        vecs[2] = '{wr: 10'd2,    exp_err: 1'b0, exp_active: 10'd2,    exp_pulses: 1};
        vecs[3] = '{wr: 10'd0,    exp_err: 1'b1, exp_active: 10'd2,    exp_pulses: 0};
        vecs[4] = '{wr: 10'd1023, exp_err: 1'b0, exp_active: 10'd1023, exp_pulses: 1};
        vecs[5] = '{wr: 10'd3,    exp_err: 1'b0, exp_active: 10'd3,    exp_pulses: 1};

        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_ratio", {22'd0, ratio}, 32'd10);
        check("rst_active", {22'd0, active_ratio}, 32'd10);
        check("rst_req", {31'd0, ratio_upd_req}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errs", {30'd0, err_range, err_timeout}, 32'd0);

        // Single handshake with a hand-driven divider acknowledge
        cfg_ratio = 10'd25;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        check("a_req_at_accept", {31'd0, ratio_upd_req}, 32'd0);
        check("a_ready_slot_full", {31'd0, cfg_ready}, 32'd0);
        check("a_busy_pending", {31'd0, busy}, 32'd1);
        tick(1);
        check("a_req_rise", {31'd0, ratio_upd_req}, 32'd1);
        check("a_ratio_loaded", {22'd0, ratio}, 32'd25);
        check("a_ready_free", {31'd0, cfg_ready}, 32'd1);
        tick(4);
        man_ack = 1'b1;
        n = 0;
        while (ratio_upd_req && n < 50) begin
            tick(1);
            n++;
        end
        // two synchroniser edges, one edge to see ack_s, two hold cycles: low on the fifth
        check("a_req_fall_edges", n, 32'd5);
        tick(3);
        check("a_active_until_ack_fall", {22'd0, active_ratio}, 32'd10);
        man_ack = 1'b0;
        wait_idle("a_idle_timeout", 50);
        check("a_active_done", {22'd0, active_ratio}, 32'd25);
        check("a_errs", {30'd0, err_range, err_timeout}, 32'd0);

        // Vector table of single writes against an auto-acking divider
        ack_auto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clear_errors();
            p0 = req_pulses;
            write_cfg(vecs[i].wr, ok);
            tick(2);
            wait_idle("tbl_idle_timeout", 100);
            check($sformatf("tbl%0d_err_range", i), {31'd0, err_range}, {31'd0, vecs[i].exp_err});
            check($sformatf("tbl%0d_active", i), {22'd0, active_ratio}, {22'd0, vecs[i].exp_active});
            check($sformatf("tbl%0d_ratio", i), {22'd0, ratio}, {22'd0, vecs[i].exp_active});
            check($sformatf("tbl%0d_pulses", i), req_pulses - p0, vecs[i].exp_pulses);
        end
        clear_errors();
        check("clr_err_range", {31'd0, err_range}, 32'd0);

        // Writes arriving during a handshake queue in the slot and stall behind it
        ack_dly = 6;
        rel_dly = 4;
        p0 = req_pulses;
        write_cfg(10'd12, ok);
        wait_req("c_req12", 10);
        write_cfg(10'd30, ok);
        check("c_ready_slot_held", {31'd0, cfg_ready}, 32'd0);
        check("c_pulses_while_held", req_pulses - p0, 32'd1);
        write_cfg(10'd40, ok);
        check("c_pulses_at_40_accept", req_pulses - p0, 32'd2);
        check("c_ratio_30_issued", {22'd0, ratio}, 32'd30);
        wait_idle("c_idle_timeout", 200);
        check("c_active_final", {22'd0, active_ratio}, 32'd40);
        check("c_pulses_total", req_pulses - p0, 32'd3);

        // Divider never acknowledges: REQ phase times out
        ack_auto = 1'b0;
        man_ack = 1'b0;
        write_cfg(10'd50, ok);
        wait_req("d_req", 10);
        n = 0;
        while (ratio_upd_req && n < 1100) begin
            tick(1);
            n++;
        end
        check("d_req_cycles", n, 32'd1024);
        check("d_err_timeout", {31'd0, err_timeout}, 32'd1);
        check("d_active_kept", {22'd0, active_ratio}, 32'd40);
        check("d_busy", {31'd0, busy}, 32'd0);
        clear_errors();
        check("d_err_cleared", {31'd0, err_timeout}, 32'd0);
        ack_auto = 1'b1;
        write_cfg(10'd60, ok);
        tick(1);
        wait_idle("d_idle_timeout", 100);
        check("d_active_after", {22'd0, active_ratio}, 32'd60);
        check("d_no_timeout", {31'd0, err_timeout}, 32'd0);

        // Reset asserted during HOLD with a second ratio waiting in the slot
        ack_auto = 1'b0;
        write_cfg(10'd33, ok);
        wait_req("e_req", 10);
        write_cfg(10'd44, ok);
        man_ack = 1'b1;
        tick(3);
        check("e_req_in_hold", {31'd0, ratio_upd_req}, 32'd1);
        p0 = req_pulses;
        rst = 1'b1;
        tick(1);
        check("e_rst_req", {31'd0, ratio_upd_req}, 32'd0);
        check("e_rst_ratio", {22'd0, ratio}, 32'd10);
        check("e_rst_active", {22'd0, active_ratio}, 32'd10);
        check("e_rst_slot_empty", {31'd0, cfg_ready}, 32'd1);
        rst = 1'b0;
        man_ack = 1'b0;
        tick(6);
        check("e_pending_discarded", req_pulses - p0, 32'd0);
        check("e_busy", {31'd0, busy}, 32'd0);
        ack_auto = 1'b1;
        write_cfg(10'd15, ok);
        tick(1);
        wait_idle("e_idle_timeout", 100);
        check("e_active_15", {22'd0, active_ratio}, 32'd15);

        // Clear and a new range error in the same cycle: set wins
        cfg_ratio = 10'd1;
        cfg_valid = 1'b1;
        cfg_clr_err = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        cfg_clr_err = 1'b0;
        check("f_set_wins", {31'd0, err_range}, 32'd1);
        check("f_ratio_kept", {22'd0, ratio}, 32'd15);
        clear_errors();
        check("f_cleared", {31'd0, err_range}, 32'd0);

        // Randomized writes against the transaction-level model
        exp_q.delete();
        last_exp = 10'd15;
        err_exp = 1'b0;
        mdl_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [9:0] v;
            ack_dly = $urandom_range(0, 6);
            rel_dly = $urandom_range(0, 6);
            if ($urandom_range(0, 4) == 0) begin
                v = 10'($urandom_range(0, 1));
            end else begin
                v = 10'($urandom_range(0, 1023));
            end
            write_cfg(v, ok);
            if (ok) begin
                if (v >= 10'd2) begin
                    exp_q.push_back(v);
                    last_exp = v;
                end else begin
                    err_exp = 1'b1;
                end
            end
            tick($urandom_range(0, 12));
        end
        tick(2);
        wait_idle("rnd_idle_timeout", 400);
        tick(2);
        mdl_en = 1'b0;
        check("rnd_all_issued", exp_q.size(), 32'd0);
        check("rnd_active", {22'd0, active_ratio}, {22'd0, last_exp});
        check("rnd_err_range", {31'd0, err_range}, {31'd0, err_exp});
        check("rnd_err_timeout", {31'd0, err_timeout}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
